// File: rtl/nx_fifo_drain.sv
// ---------------------------------------------------------------------------
// nx_fifo_drain
//
// Read-side drain engine for an nx_fifo. Pops words from the FIFO's
// empty/ren/rdata port into a 2-entry staging buffer and presents the head
// entry downstream as a registered valid/ready stream.
//
// The pop strobe fifo_ren is derived only from fifo_empty, clear, reset and
// the local fill state. It never looks at out_ready, so a late consumer
// ready does not reach the FIFO pointer logic combinationally.
//
// Parameters:
//   WIDTH       data word width (must match the attached FIFO)
//   DATA_RESET  1: staging data registers reset/clear to zero
//               0: only control state is reset, data registers are free-running
//
// Ports:
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   fifo_empty   empty flag of the attached FIFO
//   fifo_rdata   combinational head word of the FIFO
//   fifo_ren     pop strobe to the FIFO (word consumed at the same posedge)
//   clear        synchronous flush of the staging buffer
//   out_valid    stream valid (register output)
//   out_ready    stream ready from the consumer
//   out_data     stream data, head of the staging buffer (register output)
//   busy         buffer holds a word or the FIFO is non-empty
//
// Optional build macro NX_FIFO_DRAIN_STATS_EN adds:
//   beat_count   32-bit count of accepted beats, wraps
//   stall_count  16-bit count of valid-but-not-ready cycles, saturates
// ---------------------------------------------------------------------------
module nx_fifo_drain #(
    parameter int WIDTH      = 106,
    parameter bit DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef NX_FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [15:0]      stall_count
`endif
);

    // Fill state of the staging buffer: number of words held.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;
    logic             head_load;
    logic             head_from_tail;
    logic             tail_load;

    // The pop strobe is gated by reset so the FIFO is never popped while the
    // drain is held in reset, and by clear so a flush cycle loses no word.
    assign fifo_ren = rst_n && !fifo_empty && !clear && (state != S2);
    assign push     = fifo_ren;
    assign pop      = out_valid && out_ready;
    assign out_data = head;
    assign busy     = (state != S0) || !fifo_empty;

    // Next-state and data-steering decode. A push with a simultaneous pop in
    // S1 replaces the head directly; in S2 no push can occur, so a pop just
    // promotes the tail. clear overrides everything and blocks all loads.
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_tail = 1'b0;
        tail_load      = 1'b0;
        unique case (state)
            S0: begin
                if (push) begin
                    state_nxt = S1;
                    head_load = 1'b1;
                end
            end
            S1: begin
                if (push && !pop) begin
                    state_nxt = S2;
                    tail_load = 1'b1;
                end else if (push && pop) begin
                    head_load = 1'b1;
                end else if (pop) begin
                    state_nxt = S0;
                end
            end
            S2: begin
                if (pop) begin
                    state_nxt      = S1;
                    head_load      = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_nxt = S0;
            end
        endcase
        if (clear) begin
            state_nxt = S0;
            head_load = 1'b0;
            tail_load = 1'b0;
        end
    end

    // Control FSM. out_valid is kept as its own flop (a copy of the
    // "not empty" decode of the next state) so it is a pure register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != S0);
        end
    end

    // Staging data registers; the reset/clear to zero is only built when
    // DATA_RESET is set, otherwise the entries just hold stale data.
    generate
        if (DATA_RESET) begin : g_data_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    head <= '0;
                    tail <= '0;
                end else if (clear) begin
                    head <= '0;
                    tail <= '0;
                end else begin
                    if (head_load) head <= head_from_tail ? tail : fifo_rdata;
                    if (tail_load) tail <= fifo_rdata;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (head_load) head <= head_from_tail ? tail : fifo_rdata;
                if (tail_load) tail <= fifo_rdata;
            end
        end
    endgenerate

`ifdef NX_FIFO_DRAIN_STATS_EN
    // Statistics: beats accepted (wrapping) and stalled cycles (saturating).
    // A pop coinciding with clear is discarded, so clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else if (clear) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop) beat_count <= beat_count + 32'd1;
            if (out_valid && !out_ready && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/nx_fifo_drain.md
Name:
nx_fifo_drain

Overview:
- Read-side drain engine for nx_fifo instances.
- Pops words from a FIFO's empty/ren/rdata port and presents them downstream as a registered valid/ready stream through a 2-entry staging buffer.
- fifo_ren depends only on the FIFO's empty flag and local registered state, never on out_ready. This breaks the combinational path from the consumer back into the FIFO pointers.
- Sits between any nx_fifo and a consumer whose ready signal is late in the cycle.

Parameters:
- WIDTH, 106, data word width in bits; must match the attached FIFO.
- DATA_RESET, 1, 1 = staging registers reset and clear to zero; 0 = data registers are not reset, only control is reset.

Ports:
- clk  input  1  clock; all state rises on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  empty flag of the attached FIFO.
- fifo_rdata  input  WIDTH  combinational head word of the FIFO; valid while fifo_empty=0.
- fifo_ren  output  1  pop strobe to the FIFO; the word is consumed at the same posedge.
- clear  input  1  synchronous flush of the staging buffer.
- out_valid  output  1  stream data valid.
- out_ready  input  1  stream consumer ready.
- out_data  output  WIDTH  stream data, head of the staging buffer.
- busy  output  1  high when the buffer holds at least one word or fifo_empty=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, out_valid=0.
  - Both staging entries =0 if DATA_RESET=1.
  - fifo_ren=0 while in reset.
- Storage:
  - Two entries, head H and tail T.
  - cnt in {0,1,2} is held as a 2-bit state: S0=empty, S1=one word, S2=two words.
- fifo_ren:
  - fifo_ren = !fifo_empty && !clear && (cnt!=2), purely combinational from these terms.
  - fifo_ren is never asserted while fifo_empty=1, so no FIFO underflow is ever caused.
- Per-cycle events:
  - push = fifo_ren; the word captured is fifo_rdata at that posedge.
  - pop = out_valid && out_ready.
- Outputs:
  - out_valid = (cnt!=0); out_data = H.
  - Both are direct register outputs: no combinational path from inputs to out_valid or out_data.
- State transitions (clear=0):
  - S0: push -> S1, H<=rdata.
  - S1: push&!pop -> S2, T<=rdata. push&pop -> S1, H<=rdata. !push&pop -> S0. Otherwise hold.
  - S2: push is impossible. pop -> S1, H<=T. Otherwise hold.
- Throughput and latency:
  - Steady state S1 with the FIFO non-empty and out_ready=1 gives one word per cycle.
  - First-word latency: FIFO goes non-empty at cycle N -> out_valid=1 at cycle N+1.
- Ordering: strict FIFO order is preserved; no word is dropped or duplicated.
- Stall: out_valid=1 with out_ready=0 holds out_data stable; the buffer fills to S2, then fifo_ren=0.
- clear:
  - At the posedge with clear=1: cnt<=0, out_valid<=0; data entries <=0 if DATA_RESET=1.
  - fifo_ren=0 that cycle, so no word is lost from the FIFO.
  - A pop in the same cycle is discarded.
  - clear does not flush the FIFO itself; the owner drives the FIFO's own clear in parallel if required.
- Reset mid-transfer: asynchronous return to S0; words already staged are lost.
- Upstream rule: fifo_empty must not assert while the FIFO holds data.

Optional Feature:
- Macro: NX_FIFO_DRAIN_STATS_EN.
- When defined:
  - Adds output beat_count (32 bits), which increments on every pop and wraps 0xFFFFFFFF -> 0.
  - Adds output stall_count (16 bits), which increments on each cycle with out_valid=1 and out_ready=0, and saturates at 0xFFFF.
  - Both counters reset to 0 on rst_n and on clear.
- When not defined: these ports and their counters do not exist.
- Datapath behaviour is identical in both builds.

Test Plan:
1. Back-to-back drain:
   - Stimulus: load FIFO with 8 words 0x1..0x8, hold out_ready=1.
   - Response: out_valid rises one cycle after fifo_empty=0; data 0x1..0x8 appears on 8 consecutive cycles; fifo_ren is high for exactly 8 cycles; busy=0 after the last pop.
2. Backpressure:
   - Stimulus: 4 words in the FIFO, out_ready=0 for 5 cycles, then 1.
   - Response: cnt reaches 2 and fifo_ren=0 while stalled; out_data=0x1 stable throughout; then 0x1..0x4 in order; stall_count=4 when the stats macro is defined.
3. Empty guard:
   - Stimulus: fifo_empty=1 for 20 cycles with out_ready toggling.
   - Response: fifo_ren never asserts, out_valid=0, and the FIFO underflow flag never pulses.
4. Clear in S2:
   - Stimulus: fill the buffer to 2 words, pulse clear with out_ready=1.
   - Response: the next cycle has out_valid=0 and fifo_ren=0 during clear; the remaining FIFO words resume draining in order starting the cycle after clear.
5. Async reset mid-stream:
   - Stimulus: drop rst_n during a burst between posedges.
   - Response: out_valid=0 and fifo_ren=0 immediately; out_data=0 (DATA_RESET=1); after release, draining restarts from the FIFO's current head.
6. Random ready:
   - Stimulus: 1000 random words, random out_ready at 50%.
   - Response: the scoreboard sees exact order with no loss or duplication; beat_count=1000.
